raster_engine: RTL and testbench

//  Downstream of the command decoder. Accepts one decoded draw command per
//  in_valid pulse and rasterizes it, one pixel per cycle (one row per cycle
//  for CLEAR), into an internal 8x8 1-bit framebuffer. Exposes a row read port
//  for the display/output stage.

---
 rtl/raster_engine_pkg.sv | 29 ++
 rtl/raster_engine_line_stepper.sv | 68 ++++++
 rtl/raster_engine.sv | 161 ++++++++++++++++
 tb/tb_raster_engine.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/raster_engine_pkg.sv
// Shared command encodings, FSM states and geometry helpers for the raster engine.
// The command decoder upstream uses the same cmd_e encodings.
package raster_engine_pkg;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'b00,
    CMD_PIXEL = 2'b01,
    CMD_LINE  = 2'b10,
    CMD_RECT  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PIXEL,
    ST_LINE,
    ST_RECT,
    ST_CLEAR
  } state_e;

  localparam int unsigned FB_DIM = 8;

  // Last covered coordinate of a span, computed 4-bit so it saturates at 7 instead of wrapping.
  function automatic logic [2:0] clip_end(input logic [2:0] origin, input logic [2:0] len);
    logic [3:0] last;
    last = {1'b0, origin} + {1'b0, len} - 4'd1;
    return (last > 4'd7) ? 3'd7 : last[2:0];
  endfunction

endpackage

// File: rtl/raster_engine_line_stepper.sv
// Bresenham line datapath: load captures the endpoints, each step advances one pixel.
// at_end flags that (x,y) has reached the line end point.
module raster_engine_line_stepper (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  logic [2:0] x1,
  input  logic [2:0] y1,
  input  logic [2:0] x2,
  input  logic [2:0] y2,
  output logic       at_end,
  output logic [2:0] x,
  output logic [2:0] y
);

  logic [2:0]        x_q, y_q, xe_q, ye_q;
  logic signed [4:0] dx_q, dy_q, err_q, err_n;
  logic              sx_neg_q, sy_neg_q;
  logic [2:0]        adx, ady;
  logic signed [5:0] e2, dx_w, dy_w;
  logic              x_move, y_move;

  always_comb begin
    adx    = (x2 >= x1) ? (x2 - x1) : (x1 - x2);
    ady    = (y2 >= y1) ? (y2 - y1) : (y1 - y2);
    e2     = {err_q, 1'b0};
    dx_w   = {dx_q[4], dx_q};
    dy_w   = {dy_q[4], dy_q};
    x_move = (e2 >= dy_w);
    y_move = (e2 <= dx_w);
    err_n  = err_q + (x_move ? dy_q : 5'sd0) + (y_move ? dx_q : 5'sd0);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else if (load) begin
      x_q      <= x1;
      y_q      <= y1;
      xe_q     <= x2;
      ye_q     <= y2;
      dx_q     <= $signed({2'b00, adx});
      dy_q     <= -$signed({2'b00, ady});
      err_q    <= $signed({2'b00, adx}) - $signed({2'b00, ady});
      sx_neg_q <= (x2 < x1);
      sy_neg_q <= (y2 < y1);
    end else if (step) begin
      if (x_move) x_q <= sx_neg_q ? (x_q - 3'd1) : (x_q + 3'd1);
      if (y_move) y_q <= sy_neg_q ? (y_q - 3'd1) : (y_q + 3'd1);
      err_q <= err_n;
    end
  end

  assign at_end = (x_q == xe_q) && (y_q == ye_q);
  assign x      = x_q;
  assign y      = y_q;

endmodule

// File: rtl/raster_engine.sv
// Rasterizes decoded draw commands into an 8x8 1-bit framebuffer, one pixel
// (or one CLEAR row) per cycle, with a combinational row read port.
module raster_engine
  import raster_engine_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] in_cmd,
  input  logic [2:0] in_x1,
  input  logic [2:0] in_y1,
  input  logic [2:0] in_x2,
  input  logic [2:0] in_y2,
  input  logic [2:0] in_width,
  input  logic [2:0] in_height,
  input  logic [2:0] rd_row,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  state_e     state, state_n;
  logic [7:0] fb [FB_DIM];
  logic [2:0] rx, ry, x0, xe, ye;
  logic       rect_empty;
  logic       accept, finish, wr_en, clr_en, ls_load, ls_step, ls_at_end;
  logic [2:0] wr_x, wr_y, ls_x, ls_y;

  raster_engine_line_stepper u_line (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (ls_load),
    .step   (ls_step),
    .x1     (in_x1),
    .y1     (in_y1),
    .x2     (in_x2),
    .y2     (in_y2),
    .at_end (ls_at_end),
    .x      (ls_x),
    .y      (ls_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    finish  = 1'b0;
    wr_en   = 1'b0;
    clr_en  = 1'b0;
    ls_load = 1'b0;
    ls_step = 1'b0;
    wr_x    = rx;
    wr_y    = ry;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
          case (cmd_e'(in_cmd))
            CMD_CLEAR: state_n = ST_CLEAR;
            CMD_PIXEL: state_n = ST_PIXEL;
            CMD_LINE: begin
              state_n = ST_LINE;
              ls_load = 1'b1;
            end
            CMD_RECT:  state_n = ST_RECT;
          endcase
        end
      end
      ST_PIXEL: begin
        wr_en   = 1'b1;
        finish  = 1'b1;
        state_n = ST_IDLE;
      end
      ST_LINE: begin
        wr_en = 1'b1;
        wr_x  = ls_x;
        wr_y  = ls_y;
        if (ls_at_end) begin
          finish  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          ls_step = 1'b1;
        end
      end
      ST_RECT: begin
        wr_en = !rect_empty;
        if (rect_empty || (rx == xe && ry == ye)) begin
          finish  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        clr_en = 1'b1;
        if (ry == 3'(FB_DIM - 1)) begin
          finish  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Rect/clear counters: rx/ry also hold the PIXEL coordinate, ry doubles as the CLEAR row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx         <= '0;
      ry         <= '0;
      x0         <= '0;
      xe         <= '0;
      ye         <= '0;
      rect_empty <= 1'b0;
    end else if (accept) begin
      rx         <= in_x1;
      x0         <= in_x1;
      ry         <= (cmd_e'(in_cmd) == CMD_CLEAR) ? 3'd0 : in_y1;
      xe         <= clip_end(in_x1, in_width);
      ye         <= clip_end(in_y1, in_height);
      rect_empty <= (in_width == 3'd0) || (in_height == 3'd0);
    end else if (state == ST_RECT && !rect_empty) begin
      if (rx == xe) begin
        rx <= x0;
        if (ry != ye) ry <= ry + 3'd1;
      end else begin
        rx <= rx + 3'd1;
      end
    end else if (state == ST_CLEAR && ry != 3'(FB_DIM - 1)) begin
      ry <= ry + 3'd1;
    end
  end

  // NOTE: the framebuffer is 64 discrete flops, not a RAM macro, so resetting it is legitimate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < FB_DIM; r++) fb[r] <= '0;
    end else if (clr_en) begin
      fb[wr_y] <= '0;
    end else if (wr_en) begin
      fb[wr_y][wr_x] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done    <= finish;
      overrun <= in_valid && busy;
    end
  end

  assign busy    = (state != ST_IDLE);
  assign rd_data = fb[rd_row];

endmodule

// File: tb/tb_raster_engine.sv
// Self-checking bench for raster_engine: directed vector table, hand-written
// corner sequences, then random commands against a pixel-level reference model.
module tb_raster_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_cmd;
  logic [2:0] in_x1, in_y1, in_x2, in_y2, in_width, in_height;
  logic [2:0] rd_row;
  logic [7:0] rd_data;
  logic       busy, done, overrun;

  raster_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_cmd    (in_cmd),
    .in_x1     (in_x1),
    .in_y1     (in_y1),
    .in_x2     (in_x2),
    .in_y2     (in_y2),
    .in_width  (in_width),
    .in_height (in_height),
    .rd_row    (rd_row),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [63:0] m_fb;

  typedef struct {
    logic [1:0]  cmd;
    logic [2:0]  x1, y1, x2, y2, w, h;
    int          cycles;
    logic [63:0] fb;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] c, input logic [2:0] a, b, p, q, w, h);
    in_cmd = c; in_x1 = a; in_y1 = b; in_x2 = p; in_y2 = q; in_width = w; in_height = h;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [1:0] c, input logic [2:0] a, b, p, q, w, h);
    @(negedge clk);
    drive(c, a, b, p, q, w, h);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 100) check("busy_timeout", 64'(cyc), 64'd0);
  endtask

  task automatic read_fb(output logic [63:0] f);
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      #1;
      f[r*8 +: 8] = rd_data;
    end
  endtask

  task automatic run_cmd(input string name, input logic [1:0] c, input logic [2:0] a, b, p, q, w, h,
                         input int exp_cyc, input logic [63:0] exp_fb);
    int cyc;
    logic [63:0] f;
    send(c, a, b, p, q, w, h);
    wait_done(cyc);
    check({name, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({name, "_done"}, 64'(done), 64'd1);
    read_fb(f);
    check({name, "_fb"}, f, exp_fb);
  endtask

  // Reference model: operates on whole pixels with integer arithmetic.
  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_apply(input int c, x1, y1, x2, y2, w, h, output int cyc);
    cyc = 0;
    case (c)
      0: begin m_fb = '0; cyc = 8; end
      1: begin m_fb[y1*8 + x1] = 1'b1; cyc = 1; end
      2: begin
        int x, y, dx, dy, sx, sy, err, e2;
        x = x1; y = y1;
        dx = (x2 > x1) ? x2 - x1 : x1 - x2;
        dy = -((y2 > y1) ? y2 - y1 : y1 - y2);
        sx = (x1 < x2) ? 1 : -1;
        sy = (y1 < y2) ? 1 : -1;
        err = dx + dy;
        for (int k = 0; k < 20; k++) begin
          m_fb[y*8 + x] = 1'b1;
          cyc++;
          if (x == x2 && y == y2) break;
          e2 = 2 * err;
          if (e2 >= dy) begin err += dy; x += sx; end
          if (e2 <= dx) begin err += dx; y += sy; end
        end
      end
      default: begin
        if (w == 0 || h == 0) cyc = 1;
        else begin
          for (int yy = y1; yy <= imin(y1 + h - 1, 7); yy++)
            for (int xx = x1; xx <= imin(x1 + w - 1, 7); xx++) begin
              m_fb[yy*8 + xx] = 1'b1;
              cyc++;
            end
        end
      end
    endcase
  endtask

  initial begin
    int cyc, c, a, b, p, q, w, h;
    logic [63:0] f;
    logic done_seen;

    vecs[0] = '{2'b01, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 1, 64'h0000_0800_0000_0000};
    vecs[1] = '{2'b10, 3'd0, 3'd0, 3'd7, 3'd7, 3'd0, 3'd0, 8, 64'h8040_2010_0804_0201};
    vecs[2] = '{2'b10, 3'd7, 3'd2, 3'd0, 3'd2, 3'd0, 3'd0, 8, 64'h0000_0000_00FF_0000};
    vecs[3] = '{2'b10, 3'd0, 3'd0, 3'd7, 3'd3, 3'd0, 3'd0, 8, 64'h0000_0000_C030_0C03};
    vecs[4] = '{2'b10, 3'd4, 3'd4, 3'd4, 3'd4, 3'd0, 3'd0, 1, 64'h0000_0010_0000_0000};
    vecs[5] = '{2'b11, 3'd6, 3'd6, 3'd0, 3'd0, 3'd4, 3'd4, 4, 64'hC0C0_0000_0000_0000};
    vecs[6] = '{2'b11, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd3, 1, 64'h0};
    vecs[7] = '{2'b11, 3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd2, 6, 64'h0000_0000_0E0E_0000};

    rst_n = 1'b0; in_valid = 1'b0; rd_row = '0;
    in_cmd = '0; in_x1 = '0; in_y1 = '0; in_x2 = '0; in_y2 = '0; in_width = '0; in_height = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_fb(f);
    check("reset_fb", f, 64'h0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done_ovr", {62'd0, done, overrun}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].x1, vecs[i].y1, vecs[i].x2, vecs[i].y2,
              vecs[i].w, vecs[i].h, vecs[i].cycles, vecs[i].fb);
      run_cmd($sformatf("clr%0d", i), 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 8, 64'h0);
    end

    // Full frame, then CLEAR with a command dropped mid-clear.
    run_cmd("fill_rect", 2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 49, 64'h007F_7F7F_7F7F_7F7F);
    run_cmd("fill_col", 2'b10, 3'd7, 3'd0, 3'd7, 3'd7, 3'd0, 3'd0, 8, 64'h80FF_FFFF_FFFF_FFFF);
    run_cmd("fill_row", 2'b10, 3'd0, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 8, 64'hFFFF_FFFF_FFFF_FFFF);
    send(2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    drive(2'b01, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("overrun_pulse", 64'(overrun), 64'd1);
    wait_done(cyc);
    check("ovr_clear_cycles", 64'(cyc + 1), 64'd8);
    check("ovr_overrun_low", 64'(overrun), 64'd0);
    read_fb(f);
    check("ovr_dropped_fb", f, 64'h0);

    // Back-to-back: second command accepted in the done cycle.
    send(2'b01, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0);
    wait_done(cyc);
    check("b2b_first_done", 64'(done), 64'd1);
    drive(2'b01, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_accepted", {62'd0, busy, overrun}, 64'd2);
    wait_done(cyc);
    check("b2b_cycles", 64'(cyc), 64'd1);
    read_fb(f);
    check("b2b_fb", f, 64'h0000_0000_0004_0200);

    // Reset mid-LINE aborts with no done and no further writes.
    send(2'b10, 3'd0, 3'd0, 3'd7, 3'd7, 3'd0, 3'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    read_fb(f);
    check("midrst_fb", f, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) done_seen = 1'b1;
    end
    check("midrst_quiet", 64'(done_seen), 64'd0);
    read_fb(f);
    check("midrst_fb_after", f, 64'h0);

    // Random commands against the reference model.
    m_fb = '0;
    for (int i = 0; i < 60; i++) begin
      c = int'($urandom_range(0, 9));
      c = (c == 0) ? 0 : (c <= 2) ? 1 : (c <= 6) ? 2 : 3;
      a = int'($urandom_range(0, 7)); b = int'($urandom_range(0, 7));
      p = int'($urandom_range(0, 7)); q = int'($urandom_range(0, 7));
      w = int'($urandom_range(0, 7)); h = int'($urandom_range(0, 7));
      model_apply(c, a, b, p, q, w, h, cyc);
      run_cmd($sformatf("rnd%0d", i), 2'(c), 3'(a), 3'(b), 3'(p), 3'(q), 3'(w), 3'(h), cyc, m_fb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
